pipe_ifetch: RTL and testbench

PIPE_IFETCH -- requirements
Module: pipe_ifetch

---
 rtl/pipe_ifetch_if.sv | 28 ++
 rtl/pipe_ifetch.sv | 75 +++++++
 tb/tb_pipe_ifetch.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_ifetch_if.sv
// Fetch-stage bundle: downstream control, instruction ROM port and fetch outputs.
// The slave side is the fetch unit; the master side is whatever surrounds it.
interface pipe_ifetch_if #(
    parameter int XLEN   = 32,
    parameter int ROM_AW = 14,
    parameter int CNT_W  = 32
);
    logic              stall;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;
    logic [ROM_AW-1:0] imem_addr;
    logic [XLEN-1:0]   imem_rdata;
    logic              if_valid;
    logic [XLEN-1:0]   if_pc;
    logic [XLEN-1:0]   if_inst;
    logic              if_fault;
    logic [CNT_W-1:0]  retire_cnt;

    modport master (
        output stall, redirect_valid, redirect_pc, imem_rdata,
        input  imem_addr, if_valid, if_pc, if_inst, if_fault, retire_cnt
    );

    modport slave (
        input  stall, redirect_valid, redirect_pc, imem_rdata,
        output imem_addr, if_valid, if_pc, if_inst, if_fault, retire_cnt
    );
endinterface

// File: rtl/pipe_ifetch.sv
// Two-stage instruction fetch in front of a 1-cycle synchronous ROM, with
// stall hold, redirect flush, redirect fault pulse and an accepted-instruction counter.
module pipe_ifetch #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              ROM_AW   = 14,
    parameter int              CNT_W    = 32
) (
    input logic          clk,
    input logic          rst,
    pipe_ifetch_if.slave bus
);
    logic [XLEN-1:0]  r_pc_q;
    logic             r_req_v;
    logic [XLEN-1:0]  r_req_pc;
    logic             r_if_valid;
    logic [XLEN-1:0]  r_if_pc;
    logic [XLEN-1:0]  r_if_inst;
    logic             r_if_fault;
    logic [CNT_W-1:0] r_retire_cnt;

    logic             w_acc;
    logic             w_hold;
    logic             w_misalign;
    logic             w_oob;
    logic [XLEN-1:0]  w_addr_src;

    assign w_acc  = r_if_valid & ~bus.stall;
    assign w_hold = r_if_valid & bus.stall;

    // While holding, re-read the in-flight word so imem_rdata matches r_req_pc on release.
    assign w_addr_src    = w_hold ? r_req_pc : r_pc_q;
    assign bus.imem_addr = w_addr_src[ROM_AW+1:2];

    assign w_misalign = |bus.redirect_pc[1:0];
    assign w_oob      = |(bus.redirect_pc >> (ROM_AW + 2));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_q       <= RESET_PC;
            r_req_v      <= 1'b0;
            r_req_pc     <= '0;
            r_if_valid   <= 1'b0;
            r_if_pc      <= '0;
            r_if_inst    <= '0;
            r_if_fault   <= 1'b0;
            r_retire_cnt <= '0;
        end else begin
            // The output instruction is taken even if a redirect lands on the same edge.
            if (w_acc) begin
                r_retire_cnt <= r_retire_cnt + CNT_W'(1);
            end
            r_if_fault <= bus.redirect_valid & (w_misalign | w_oob);

            if (bus.redirect_valid) begin
                r_pc_q     <= {bus.redirect_pc[XLEN-1:2], 2'b00};
                r_req_v    <= 1'b0;
                r_if_valid <= 1'b0;
            end else if (!w_hold) begin
                r_if_valid <= r_req_v;
                r_if_pc    <= r_req_pc;
                r_if_inst  <= bus.imem_rdata;
                r_req_v    <= 1'b1;
                r_req_pc   <= r_pc_q;
                r_pc_q     <= r_pc_q + XLEN'(4);
            end
        end
    end

    assign bus.if_valid   = r_if_valid;
    assign bus.if_pc      = r_if_pc;
    assign bus.if_inst    = r_if_inst;
    assign bus.if_fault   = r_if_fault;
    assign bus.retire_cnt = r_retire_cnt;
endmodule

// File: tb/tb_pipe_ifetch.sv
// Bench for pipe_ifetch: directed scenarios then random stall/redirect/reset traffic,
// checked against a stream-level model of the fetch output.
module tb_pipe_ifetch;
    localparam int XLEN   = 32;
    localparam int ROM_AW = 14;
    localparam int CNT_W  = 32;
    localparam logic [31:0] ROM_BASE = 32'h1000_0000;

    logic clk;
    logic rst;
    logic [31:0] rom_q;

    int n_checks;
    int n_fail;

    pipe_ifetch_if #(.XLEN(XLEN), .ROM_AW(ROM_AW), .CNT_W(CNT_W)) bus ();

    pipe_ifetch #(
        .XLEN(XLEN), .RESET_PC(32'h0), .ROM_AW(ROM_AW), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction ROM: word i holds ROM_BASE + i, one cycle read latency.
    always_ff @(posedge clk) rom_q <= ROM_BASE + 32'(bus.imem_addr);
    assign bus.imem_rdata = rom_q;

    // Stream model: what the fetch output should show, not how the pipe holds it.
    bit          m_init;
    bit          m_valid;
    bit          m_bub;
    bit          m_zero;
    logic [31:0] m_pc;
    logic [31:0] m_next;
    logic [31:0] m_retire;
    bit          m_fault;

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return (pc >> 2) & ((32'd1 << ROM_AW) - 1);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit s, input bit rv, input logic [31:0] rpc);
        m_zero = 1'b0;
        if (r) begin
            m_valid  = 1'b0;
            m_bub    = 1'b1;
            m_next   = 32'h0;
            m_retire = 32'h0;
            m_fault  = 1'b0;
            m_zero   = 1'b1;
            m_init   = 1'b1;
        end else begin
            if (m_valid && !s) m_retire = m_retire + 1;
            m_fault = rv && ((rpc[1:0] != 2'b00) || ((rpc >> (ROM_AW + 2)) != 0));
            if (rv) begin
                m_valid = 1'b0;
                m_bub   = 1'b1;
                m_next  = {rpc[31:2], 2'b00};
            end else if (m_valid && s) begin
                // downstream holds the same instruction
            end else if (m_bub) begin
                m_bub   = 1'b0;
                m_valid = 1'b0;
            end else begin
                m_valid = 1'b1;
                m_pc    = m_next;
                m_next  = m_next + 32'd4;
            end
        end
    endtask

    task automatic step(input bit r, input bit s, input bit rv, input logic [31:0] rpc);
        logic [31:0] exp_addr;
        rst                = r;
        bus.stall          = s;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        #1;
        if (m_init) begin
            // Next launch address: the pending instruction while held or just flushed,
            // otherwise the one after it.
            exp_addr = ((m_valid && s) || m_bub) ? word_of(m_next) : word_of(m_next + 32'd4);
            check("imem_addr", 64'(bus.imem_addr), 64'(exp_addr));
        end
        @(posedge clk);
        model_edge(r, s, rv, rpc);
        #1;
        check("if_valid", 64'(bus.if_valid), 64'(m_valid));
        if (m_valid) begin
            check("if_pc", 64'(bus.if_pc), 64'(m_pc));
            check("if_inst", 64'(bus.if_inst), 64'(ROM_BASE + word_of(m_pc)));
        end
        if (m_zero) begin
            check("rst_pc", 64'(bus.if_pc), 64'h0);
            check("rst_inst", 64'(bus.if_inst), 64'h0);
        end
        check("if_fault", 64'(bus.if_fault), 64'(m_fault));
        check("retire_cnt", 64'(bus.retire_cnt), 64'(m_retire));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_init   = 1'b0;
        m_valid  = 1'b0;
        m_bub    = 1'b1;
        m_zero   = 1'b0;
        m_pc     = 32'h0;
        m_next   = 32'h0;
        m_retire = 32'h0;
        m_fault  = 1'b0;
        rst                = 1'b1;
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        @(negedge clk);

        // Reset, fill, then stall on PC 8 for three cycles.
        step(1, 0, 0, 0);
        step(1, 1, 1, 32'h80);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        check("dir_pc8", 64'(bus.if_pc), 64'h8);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        check("dir_hold_inst", 64'(bus.if_inst), 64'h1000_0002);
        step(0, 0, 0, 0);
        check("dir_pc_c", 64'(bus.if_pc), 64'hC);
        step(0, 0, 0, 0);

        // Redirect to 0x40 while showing 0x10.
        step(0, 0, 1, 32'h40);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("dir_redir_inst", 64'(bus.if_inst), 64'h1000_0010);
        step(0, 0, 0, 0);

        // Redirect together with stall, then faulting redirects.
        step(0, 1, 1, 32'h100);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        step(0, 0, 1, 32'h42);
        step(0, 0, 0, 0);
        check("dir_fault_clear", 64'(bus.if_fault), 64'h0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 32'h1 << (ROM_AW + 2));
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0);

        // Mid-stream reset discards everything.
        step(1, 1, 1, 32'h44);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            bit          r;
            bit          s;
            bit          rv;
            logic [31:0] rpc;
            int unsigned sel;
            r   = ($urandom_range(0, 99) < 1);
            s   = ($urandom_range(0, 99) < 30);
            rv  = ($urandom_range(0, 99) < 6);
            sel = $urandom_range(0, 9);
            if (sel < 7)      rpc = {16'h0, 14'($urandom_range(0, 16383)), 2'b00};
            else if (sel < 9) rpc = {16'h0, 14'($urandom_range(0, 16383)), 2'($urandom_range(1, 3))};
            else              rpc = $urandom | 32'h0001_0000;
            step(r, s, rv, rpc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
